// File: rtl/display_scan_scheduler.sv
// Round-robin scheduler that time-shares one BCD-to-double-seven-segment decoder
// among NUM_CH requesters and latches each result into a per-channel display register.
module display_scan_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [NUM_CH*4-1:0]    ch_value,
  output logic [NUM_CH-1:0]      ch_ack,
  input  logic                   blank_all,
  output logic [3:0]             dec_bin,
  input  logic [13:0]            dec_seg,
  output logic [NUM_CH*14-1:0]   disp_seg,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [13:0] BLANK = 14'h3FFF;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] grant_reg;
  logic [CNT_W-1:0] settle_cnt_reg;
  logic [13:0]      disp_reg [NUM_CH];

  logic [IDX_W-1:0] cand_idx [NUM_CH];
  logic [3:0]       val_arr  [NUM_CH];
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // cand_idx[gi] is the channel examined at search offset gi from rr_ptr
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic [SUM_W-1:0] raw;
    assign raw           = {1'b0, rr_ptr_reg} + SUM_W'(gi);
    assign cand_idx[gi]  = (raw >= SUM_W'(NUM_CH)) ? IDX_W'(raw - SUM_W'(NUM_CH))
                                                   : raw[IDX_W-1:0];
    assign val_arr[gi]   = ch_value[4*gi +: 4];
    assign disp_seg[14*gi +: 14] = disp_reg[gi];
  end

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (ch_req[cand_idx[j]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      grant_reg      <= '0;
      settle_cnt_reg <= '0;
      dec_bin        <= '0;
      ch_ack         <= '0;
      busy           <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) disp_reg[i] <= BLANK;
    end else begin
      ch_ack <= '0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            grant_reg      <= win_idx;
            dec_bin        <= val_arr[win_idx];
            settle_cnt_reg <= CNT_W'(SETTLE_CYC - 1);
            state_reg      <= SETTLE;
            busy           <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt_reg != '0) settle_cnt_reg <= settle_cnt_reg - 1'b1;
          else                      state_reg      <= CAPTURE;
        end
        CAPTURE: begin
          // dec_bin is still held here, so dec_seg is stable when written below
          ch_ack[grant_reg] <= 1'b1;
          rr_ptr_reg        <= (grant_reg == IDX_W'(NUM_CH - 1)) ? '0 : grant_reg + 1'b1;
          dec_bin           <= '0;
          state_reg         <= IDLE;
          busy              <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (blank_all)
          disp_reg[i] <= BLANK;
        else if (state_reg == CAPTURE && grant_reg == IDX_W'(i))
          disp_reg[i] <= dec_seg;
      end
    end
  end

endmodule
